// File: rtl/core_result_arbiter_pkg.sv
// Shared types and widths for the RC4 cracking-core result arbiter.
package crack_pkg;

    localparam int unsigned KEY_W   = 24;
    localparam int unsigned CYCLE_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RELEASE,
        SEARCH,
        FOUND,
        EXHAUSTED
    } arb_state_t;

    // Index width for an N-entry vector, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/core_result_arbiter_if.sv
// Bundle between the cracking cores / display logic and the result arbiter.
interface core_result_arbiter_if #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned KEY_W   = crack_pkg::KEY_W
);
    import crack_pkg::*;

    localparam int unsigned IDX_W = idx_w(N_CORES);

    logic                       start;
    logic [N_CORES-1:0]         core_success;
    logic [N_CORES-1:0]         core_total_failure;
    logic [N_CORES*KEY_W-1:0]   core_secret_key;

    logic                       core_hold;
    logic                       stop;
    logic                       busy;
    logic                       found;
    logic                       exhausted;
    logic                       timed_out;
    logic [IDX_W-1:0]           winner_idx;
    logic [KEY_W-1:0]           found_key;
    logic [CYCLE_W-1:0]         cycle_count;

    // Arbiter side
    modport slave (
        input  start, core_success, core_total_failure, core_secret_key,
        output core_hold, stop, busy, found, exhausted, timed_out,
               winner_idx, found_key, cycle_count
    );

    // Core / controller side
    modport master (
        output start, core_success, core_total_failure, core_secret_key,
        input  core_hold, stop, busy, found, exhausted, timed_out,
               winner_idx, found_key, cycle_count
    );

endinterface

// File: rtl/core_result_arbiter_lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_index #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan downwards so the lowest set bit is written last and wins.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/core_result_arbiter.sv
// Collects success/failure from N cracking cores, latches the winning key,
// broadcasts stop and owns the hold/run control of the cores.
module core_result_arbiter #(
    parameter int unsigned N_CORES    = 4,
    parameter int unsigned KEY_W      = crack_pkg::KEY_W,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    core_result_arbiter_if.slave  bus
);
    import crack_pkg::*;

    localparam int unsigned        IDX_W      = idx_w(N_CORES);
    localparam logic [CYCLE_W-1:0] CNT_SAT    = '1;
    localparam bit                 TIMEOUT_EN = (MAX_CYCLES != 0);
    localparam logic [CYCLE_W-1:0] TIMEOUT_AT = CYCLE_W'(MAX_CYCLES - 1);

    arb_state_t          state_q, state_d;
    logic                core_hold_q, core_hold_d;
    logic                stop_q, stop_d;
    logic                busy_q, busy_d;
    logic                found_q, found_d;
    logic                exhausted_q, exhausted_d;
    logic                timed_out_q, timed_out_d;
    logic [IDX_W-1:0]    winner_idx_q, winner_idx_d;
    logic [KEY_W-1:0]    found_key_q, found_key_d;
    logic [CYCLE_W-1:0]  cycle_count_q, cycle_count_d;

    logic [IDX_W-1:0]    win_idx;
    logic                win_any;
    logic [KEY_W-1:0]    win_key;
    logic                all_failed;
    logic [CYCLE_W-1:0]  cycle_count_inc;

    lowest_set_index #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_lowest_set_index (
        .vec (bus.core_success),
        .idx (win_idx),
        .any (win_any)
    );

    // Key of the winning core, sampled in the same cycle success is seen.
    always_comb begin
        win_key = '0;
        for (int i = 0; i < int'(N_CORES); i++) begin
            if (IDX_W'(i) == win_idx) begin
                win_key = bus.core_secret_key[i*KEY_W +: KEY_W];
            end
        end
    end

    assign all_failed      = &bus.core_total_failure;
    assign cycle_count_inc = (cycle_count_q == CNT_SAT) ? cycle_count_q
                                                        : cycle_count_q + CYCLE_W'(1);

    always_comb begin
        state_d       = state_q;
        core_hold_d   = core_hold_q;
        stop_d        = stop_q;
        busy_d        = busy_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        timed_out_d   = timed_out_q;
        winner_idx_d  = winner_idx_q;
        found_key_d   = found_key_q;
        cycle_count_d = cycle_count_q;

        unique case (state_q)
            // Idle and both terminal states accept a new search; the cores are put
            // back into hold for the RELEASE cycle so they re-initialise.
            IDLE, FOUND, EXHAUSTED: begin
                if (bus.start) begin
                    state_d       = RELEASE;
                    core_hold_d   = 1'b1;
                    stop_d        = 1'b0;
                    busy_d        = 1'b0;
                    found_d       = 1'b0;
                    exhausted_d   = 1'b0;
                    timed_out_d   = 1'b0;
                    winner_idx_d  = '0;
                    found_key_d   = '0;
                    cycle_count_d = '0;
                end
            end

            RELEASE: begin
                state_d     = SEARCH;
                core_hold_d = 1'b0;
                stop_d      = 1'b0;
                busy_d      = 1'b1;
            end

            // Precedence: success > all cores failed > timeout.
            SEARCH: begin
                cycle_count_d = cycle_count_inc;
                if (win_any) begin
                    state_d      = FOUND;
                    found_d      = 1'b1;
                    stop_d       = 1'b1;
                    busy_d       = 1'b0;
                    winner_idx_d = win_idx;
                    found_key_d  = win_key;
                end else if (all_failed) begin
                    state_d     = EXHAUSTED;
                    exhausted_d = 1'b1;
                    stop_d      = 1'b1;
                    busy_d      = 1'b0;
                end else if (TIMEOUT_EN && (cycle_count_q == TIMEOUT_AT)) begin
                    state_d     = EXHAUSTED;
                    exhausted_d = 1'b1;
                    timed_out_d = 1'b1;
                    stop_d      = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                core_hold_d = 1'b1;
                stop_d      = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            core_hold_q   <= 1'b1;
            stop_q        <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            timed_out_q   <= 1'b0;
            winner_idx_q  <= '0;
            found_key_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            core_hold_q   <= core_hold_d;
            stop_q        <= stop_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            timed_out_q   <= timed_out_d;
            winner_idx_q  <= winner_idx_d;
            found_key_q   <= found_key_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.core_hold   = core_hold_q;
    assign bus.stop        = stop_q;
    assign bus.busy        = busy_q;
    assign bus.found       = found_q;
    assign bus.exhausted   = exhausted_q;
    assign bus.timed_out   = timed_out_q;
    assign bus.winner_idx  = winner_idx_q;
    assign bus.found_key   = found_key_q;
    assign bus.cycle_count = cycle_count_q;

endmodule
